// File: rtl/indication_arbiter.sv
// Four-requester message arbiter for a shared indication channel: round-robin
// grant per message, one-entry output buffer, whole messages never interleave.
module indication_arbiter #(
    parameter int width = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [3:0]       pending,
    input  logic             in0_enq__ENA,
    input  logic [width-1:0] in0_enq_v,
    input  logic             in0_enq_last,
    output logic             in0_enq__RDY,
    input  logic             in1_enq__ENA,
    input  logic [width-1:0] in1_enq_v,
    input  logic             in1_enq_last,
    output logic             in1_enq__RDY,
    input  logic             in2_enq__ENA,
    input  logic [width-1:0] in2_enq_v,
    input  logic             in2_enq_last,
    output logic             in2_enq__RDY,
    input  logic             in3_enq__ENA,
    input  logic [width-1:0] in3_enq_v,
    input  logic             in3_enq_last,
    output logic             in3_enq__RDY,
    output logic             out_enq__ENA,
    output logic [width-1:0] out_enq_v,
    output logic             out_enq_last,
    input  logic             out_enq__RDY,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [15:0]      msgCount
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q;
    logic [1:0]         grant_q;
    logic [1:0]         rrPtr_q;
    logic [15:0]        msgCount_q;
    logic [width-1:0]   obufV_q;
    logic               obufLast_q;
    logic               obufValid_q;

    logic [3:0]         ena;
    logic               canAccept;
    logic               accept;
    logic               drain;
    logic [width-1:0]   selV;
    logic               selLast;
    logic [1:0]         winner_d;
    logic [1:0]         idx;
    logic               found;

    assign ena       = {in3_enq__ENA, in2_enq__ENA, in1_enq__ENA, in0_enq__ENA};
    assign canAccept = !obufValid_q || out_enq__RDY;
    assign drain     = obufValid_q && out_enq__RDY;
    assign accept    = (state_q == LOCKED) && canAccept && ena[grant_q];

    always_comb begin
        selV    = in0_enq_v;
        selLast = in0_enq_last;
        case (grant_q)
            2'd1:    begin selV = in1_enq_v; selLast = in1_enq_last; end
            2'd2:    begin selV = in2_enq_v; selLast = in2_enq_last; end
            2'd3:    begin selV = in3_enq_v; selLast = in3_enq_last; end
            default: begin selV = in0_enq_v; selLast = in0_enq_last; end
        endcase
    end

    // First pending requester at or after the round-robin pointer wins.
    always_comb begin
        winner_d = rrPtr_q;
        found    = 1'b0;
        idx      = rrPtr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rrPtr_q + 2'(k);
            if (!found && pending[idx]) begin
                winner_d = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            grant_q     <= 2'd0;
            rrPtr_q     <= 2'd0;
            msgCount_q  <= 16'd0;
            obufV_q     <= '0;
            obufLast_q  <= 1'b0;
            obufValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending != 4'd0) begin
                        grant_q <= winner_d;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && selLast) begin
                        state_q    <= IDLE;
                        rrPtr_q    <= grant_q + 2'd1;
                        msgCount_q <= msgCount_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A load on the drain edge wins, so back-to-back beats keep the buffer full.
            if (accept) begin
                obufV_q     <= selV;
                obufLast_q  <= selLast;
                obufValid_q <= 1'b1;
            end else if (drain) begin
                obufValid_q <= 1'b0;
            end
        end
    end

    assign in0_enq__RDY = (state_q == LOCKED) && (grant_q == 2'd0) && canAccept;
    assign in1_enq__RDY = (state_q == LOCKED) && (grant_q == 2'd1) && canAccept;
    assign in2_enq__RDY = (state_q == LOCKED) && (grant_q == 2'd2) && canAccept;
    assign in3_enq__RDY = (state_q == LOCKED) && (grant_q == 2'd3) && canAccept;

    assign out_enq__ENA = drain;
    assign out_enq_v    = obufV_q;
    assign out_enq_last = obufLast_q;
    assign grant        = grant_q;
    assign busy         = (state_q == LOCKED);
    assign msgCount     = msgCount_q;

endmodule
